// File: rtl/io_master.sv
// I/O bus initiator: runs host commands (read, write, bit set/clear, poll-with-timeout)
// on the MCU's 8-bit I/O register bus and returns one response per command.
module io_master #(
  parameter int unsigned POLL_LIMIT = 1000
) (
  input  logic       clock,
  input  logic       reset,
  input  logic       cmd_valid,
  output logic       cmd_ready,
  input  logic [2:0] cmd_op,
  input  logic [7:0] cmd_addr,
  input  logic [7:0] cmd_data,
  input  logic [7:0] cmd_mask,
  output logic       rsp_valid,
  input  logic       rsp_ready,
  output logic [7:0] rsp_data,
  output logic       rsp_err,
  output logic       busy,
  output logic [7:0] io_addr,
  output logic       io_we,
  output logic [7:0] io_wdata,
  input  logic [7:0] io_rdata,
  output logic [2:0] dbg_state
);

  // Handshakes: a transfer happens on a rising edge where valid and ready are both
  // high; valid and its payload stay stable until that edge, ready may change freely.

  localparam logic [2:0] OP_WRITE = 3'd0;
  localparam logic [2:0] OP_READ  = 3'd1;
  localparam logic [2:0] OP_SET   = 3'd2;
  localparam logic [2:0] OP_CLR   = 3'd3;
  localparam logic [2:0] OP_POLL  = 3'd4;

  localparam logic [15:0] LIMIT = 16'(POLL_LIMIT);

  typedef enum logic [2:0] {
    S_IDLE = 3'd0,
    S_RD   = 3'd1,
    S_WR   = 3'd2,
    S_POLL = 3'd3,
    S_RESP = 3'd4
  } state_t;

  state_t      state_q;
  logic [2:0]  op_q;
  logic [7:0]  data_q;
  logic [7:0]  mask_q;
  logic [7:0]  io_addr_q;
  logic        io_we_q;
  logic [7:0]  io_wdata_q;
  logic [7:0]  rsp_data_q;
  logic        rsp_err_q;
  logic [15:0] poll_cnt_q;

  logic [7:0]  wval_d;
  logic [15:0] poll_cnt_d;
  logic        poll_hit;

  // Read-modify-write value for SET/CLR, formed from the byte being read this cycle.
  always_comb begin
    wval_d     = io_rdata & ~data_q;
    if (op_q == OP_SET) begin
      wval_d = io_rdata | data_q;
    end
    poll_cnt_d = poll_cnt_q + 16'd1;
    poll_hit   = ((io_rdata & mask_q) == (data_q & mask_q));
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q    <= S_IDLE;
      op_q       <= 3'd0;
      data_q     <= 8'h00;
      mask_q     <= 8'h00;
      io_addr_q  <= 8'h00;
      io_we_q    <= 1'b0;
      io_wdata_q <= 8'h00;
      rsp_data_q <= 8'h00;
      rsp_err_q  <= 1'b0;
      poll_cnt_q <= 16'd0;
    end else begin
      case (state_q)
        S_IDLE: begin
          if (cmd_valid) begin
            op_q       <= cmd_op;
            data_q     <= cmd_data;
            mask_q     <= cmd_mask;
            io_addr_q  <= cmd_addr;
            poll_cnt_q <= 16'd0;
            case (cmd_op)
              OP_WRITE: begin
                io_we_q    <= 1'b1;
                io_wdata_q <= cmd_data;
                rsp_data_q <= cmd_data;
                rsp_err_q  <= 1'b0;
                state_q    <= S_WR;
              end
              OP_READ, OP_SET, OP_CLR: state_q <= S_RD;
              OP_POLL: state_q <= S_POLL;
              default: begin
                rsp_data_q <= 8'h00;
                rsp_err_q  <= 1'b1;
                state_q    <= S_RESP;
              end
            endcase
          end
        end
        S_RD: begin
          rsp_err_q <= 1'b0;
          if (op_q == OP_READ) begin
            rsp_data_q <= io_rdata;
            state_q    <= S_RESP;
          end else begin
            io_we_q    <= 1'b1;
            io_wdata_q <= wval_d;
            rsp_data_q <= wval_d;
            state_q    <= S_WR;
          end
        end
        S_WR: begin
          io_we_q <= 1'b0;
          state_q <= S_RESP;
        end
        S_POLL: begin
          // poll_cnt_d is the 1-based number of the sample being taken now.
          poll_cnt_q <= poll_cnt_d;
          if (poll_hit) begin
            rsp_data_q <= io_rdata;
            rsp_err_q  <= 1'b0;
            state_q    <= S_RESP;
          end else if (poll_cnt_d == LIMIT) begin
            rsp_data_q <= io_rdata;
            rsp_err_q  <= 1'b1;
            state_q    <= S_RESP;
          end
        end
        S_RESP: begin
          if (rsp_ready) begin
            state_q <= S_IDLE;
          end
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

  assign cmd_ready = (state_q == S_IDLE);
  assign busy      = (state_q != S_IDLE);
  assign rsp_valid = (state_q == S_RESP);
  assign rsp_data  = rsp_data_q;
  assign rsp_err   = rsp_err_q;
  assign io_addr   = io_addr_q;
  assign io_we     = io_we_q;
  assign io_wdata  = io_wdata_q;
  assign dbg_state = state_q;

endmodule

// File: tb/tb_io_master.sv
// Directed bench for io_master: a small I/O register file model answers the bus,
// expected values are hand-computed constants.
module tb_io_master;

  logic       clock;
  logic       reset;
  logic       cmd_valid;
  logic       cmd_ready;
  logic [2:0] cmd_op;
  logic [7:0] cmd_addr;
  logic [7:0] cmd_data;
  logic [7:0] cmd_mask;
  logic       rsp_valid;
  logic       rsp_ready;
  logic [7:0] rsp_data;
  logic       rsp_err;
  logic       busy;
  logic [7:0] io_addr;
  logic       io_we;
  logic [7:0] io_wdata;
  logic [7:0] io_rdata;
  logic [2:0] dbg_state;

  int n_checks = 0;
  int n_errors = 0;

  // I/O register file; ovr_* lets a second stimulus change a register mid-poll.
  logic [7:0] regs [0:255] = '{default: 8'h00};
  logic       ovr_en   = 1'b0;
  logic [7:0] ovr_addr = 8'h00;
  logic [7:0] ovr_val  = 8'h00;

  assign io_rdata = (ovr_en && io_addr == ovr_addr) ? ovr_val : regs[io_addr];

  always @(posedge clock) begin
    if (!reset && io_we) regs[io_addr] <= io_wdata;
  end

  io_master #(.POLL_LIMIT(4)) dut (
    .clock     (clock),
    .reset     (reset),
    .cmd_valid (cmd_valid),
    .cmd_ready (cmd_ready),
    .cmd_op    (cmd_op),
    .cmd_addr  (cmd_addr),
    .cmd_data  (cmd_data),
    .cmd_mask  (cmd_mask),
    .rsp_valid (rsp_valid),
    .rsp_ready (rsp_ready),
    .rsp_data  (rsp_data),
    .rsp_err   (rsp_err),
    .busy      (busy),
    .io_addr   (io_addr),
    .io_we     (io_we),
    .io_wdata  (io_wdata),
    .io_rdata  (io_rdata),
    .dbg_state (dbg_state)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  initial begin
    #200000;
    $display("FAIL watchdog expired before end of test");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s got=0x%0h exp=0x%0h", tag, got, exp);
    end
  endtask

  // Issue one command, measure response latency (cycles after the accept edge),
  // observe write pulses, optionally hold off the response, then consume it.
  task automatic do_cmd(input string tag, input logic [2:0] op, input logic [7:0] addr,
                        input logic [7:0] data, input logic [7:0] mask,
                        input int exp_lat, input logic [7:0] exp_data, input logic exp_err,
                        input int exp_we_lat, input int hold);
    int lat;
    int pulses;
    int we_lat;
    logic [7:0] we_addr;
    logic [7:0] we_data;
    pulses  = 0;
    we_lat  = 0;
    we_addr = 8'h00;
    we_data = 8'h00;
    cmd_valid = 1'b1;
    cmd_op    = op;
    cmd_addr  = addr;
    cmd_data  = data;
    cmd_mask  = mask;
    @(posedge clock);
    #1;
    cmd_valid = 1'b0;
    lat = 1;
    while (!rsp_valid && lat < 40) begin
      if (io_we) begin
        pulses++;
        we_lat  = lat;
        we_addr = io_addr;
        we_data = io_wdata;
      end
      @(posedge clock);
      #1;
      lat++;
    end
    if (io_we) pulses++;
    check({tag, "_lat"}, lat, exp_lat);
    check({tag, "_data"}, {24'd0, rsp_data}, {24'd0, exp_data});
    check({tag, "_err"}, {31'd0, rsp_err}, {31'd0, exp_err});
    check({tag, "_we_pulses"}, pulses, (exp_we_lat != 0) ? 1 : 0);
    check({tag, "_we_cycle"}, we_lat, exp_we_lat);
    if (exp_we_lat != 0) begin
      check({tag, "_we_addr"}, {24'd0, we_addr}, {24'd0, addr});
      check({tag, "_we_data"}, {24'd0, we_data}, {24'd0, exp_data});
    end
    for (int i = 0; i < hold; i++) begin
      @(posedge clock);
      #1;
      check({tag, "_hold_valid"}, {31'd0, rsp_valid}, 32'd1);
      check({tag, "_hold_data"}, {24'd0, rsp_data}, {24'd0, exp_data});
      check({tag, "_hold_err"}, {31'd0, rsp_err}, {31'd0, exp_err});
      check({tag, "_hold_ready"}, {31'd0, cmd_ready}, 32'd0);
    end
    rsp_ready = 1'b1;
    @(posedge clock);
    #1;
    rsp_ready = 1'b0;
    check({tag, "_done_ready"}, {31'd0, cmd_ready}, 32'd1);
    check({tag, "_done_valid"}, {31'd0, rsp_valid}, 32'd0);
  endtask

  initial begin
    reset     = 1'b1;
    cmd_valid = 1'b0;
    cmd_op    = 3'd0;
    cmd_addr  = 8'h00;
    cmd_data  = 8'h00;
    cmd_mask  = 8'h00;
    rsp_ready = 1'b0;
    repeat (2) @(posedge clock);
    #1;
    reset = 1'b0;

    check("rst_cmd_ready", {31'd0, cmd_ready}, 32'd1);
    check("rst_rsp_valid", {31'd0, rsp_valid}, 32'd0);
    check("rst_rsp_data", {24'd0, rsp_data}, 32'd0);
    check("rst_rsp_err", {31'd0, rsp_err}, 32'd0);
    check("rst_busy", {31'd0, busy}, 32'd0);
    check("rst_io_addr", {24'd0, io_addr}, 32'd0);
    check("rst_io_we", {31'd0, io_we}, 32'd0);
    check("rst_io_wdata", {24'd0, io_wdata}, 32'd0);

    // WRITE then READ back
    do_cmd("wr3c", 3'd0, 8'h3c, 8'h5A, 8'h00, 2, 8'h5A, 1'b0, 1, 0);
    check("reg3c", {24'd0, regs[8'h3c]}, 32'h5A);
    do_cmd("rd3c", 3'd1, 8'h3c, 8'h00, 8'h00, 2, 8'h5A, 1'b0, 0, 0);

    // SET / CLR read-modify-write on 0x81 preloaded with 0xF0
    do_cmd("pre81", 3'd0, 8'h81, 8'hF0, 8'h00, 2, 8'hF0, 1'b0, 1, 0);
    do_cmd("set81", 3'd2, 8'h81, 8'h0F, 8'h00, 3, 8'hFF, 1'b0, 2, 0);
    do_cmd("clr81", 3'd3, 8'h81, 8'h30, 8'h00, 3, 8'hCF, 1'b0, 2, 0);
    check("reg81", {24'd0, regs[8'h81]}, 32'hCF);

    // POLL 0x01 for bit 7; register changes to 0x80 during the 3rd sample
    ovr_addr = 8'h01;
    ovr_val  = 8'h80;
    fork
      do_cmd("poll01", 3'd4, 8'h01, 8'h80, 8'h80, 4, 8'h80, 1'b0, 0, 0);
      begin
        repeat (3) @(posedge clock);
        #1;
        ovr_en = 1'b1;
      end
    join
    ovr_en = 1'b0;

    // POLL timeout after POLL_LIMIT=4 samples
    do_cmd("poll_to", 3'd4, 8'h20, 8'h01, 8'h01, 5, 8'h00, 1'b1, 0, 0);

    // Mask 0 matches on the first sample
    do_cmd("poll_m0", 3'd4, 8'h3c, 8'h00, 8'h00, 2, 8'h5A, 1'b0, 0, 0);

    // Reserved ops, op 6 with 5 cycles of response backpressure
    do_cmd("op6", 3'd6, 8'h3c, 8'hAA, 8'h00, 1, 8'h00, 1'b1, 0, 5);
    do_cmd("op7", 3'd7, 8'h10, 8'h00, 8'h00, 1, 8'h00, 1'b1, 0, 0);
    check("reg3c_after_rsvd", {24'd0, regs[8'h3c]}, 32'h5A);

    // Reset during POLL aborts it without a response
    cmd_valid = 1'b1;
    cmd_op    = 3'd4;
    cmd_addr  = 8'h20;
    cmd_data  = 8'h01;
    cmd_mask  = 8'h01;
    @(posedge clock);
    #1;
    cmd_valid = 1'b0;
    check("prst_busy", {31'd0, busy}, 32'd1);
    @(posedge clock);
    #1;
    reset = 1'b1;
    @(posedge clock);
    #1;
    reset = 1'b0;
    check("prst_cmd_ready", {31'd0, cmd_ready}, 32'd1);
    check("prst_rsp_valid", {31'd0, rsp_valid}, 32'd0);
    check("prst_io_we", {31'd0, io_we}, 32'd0);
    check("prst_busy_idle", {31'd0, busy}, 32'd0);
    for (int i = 0; i < 6; i++) begin
      @(posedge clock);
      #1;
      check("prst_no_rsp", {30'd0, rsp_valid, io_we}, 32'd0);
    end
    do_cmd("rd81_after_rst", 3'd1, 8'h81, 8'h00, 8'h00, 2, 8'hCF, 1'b0, 0, 0);

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/io_master.md
# io_master

I/O bus initiator for the MCU's 8-bit I/O register space. It accepts commands from a host-side source such as a debug bridge or test sequencer over a valid/ready handshake. It then drives the same address/write-enable/write-data/read-data bus that the CPU core uses toward the I/O register block. Supported commands are single reads and writes, bit set/clear read-modify-write, and poll-until-match with a timeout. One response is returned per command.

## Interface

- POLL_LIMIT, 1000: maximum number of poll samples before timeout; legal range 1..65535.

- clock  in  1  master clock
- reset  in  1  synchronous, active-high reset
- cmd_valid  in  1  command present
- cmd_ready  out  1  block can accept a command; high only in IDLE
- cmd_op  in  3  0 WRITE, 1 READ, 2 SET, 3 CLR, 4 POLL, 5–7 reserved
- cmd_addr  in  8  target I/O address
- cmd_data  in  8  write data, bit pattern, or poll compare value
- cmd_mask  in  8  poll compare mask; ignored by other ops
- rsp_valid  out  1  response present
- rsp_ready  in  1  response consumer ready
- rsp_data  out  8  result byte
- rsp_err  out  1  1 = timeout or reserved op
- busy  out  1  state is not IDLE
- io_addr  out  8  I/O register address
- io_we  out  1  I/O write enable; single-cycle pulse
- io_wdata  out  8  I/O write data
- io_rdata  in  8  I/O read data, combinational from io_addr

## Operation

- States: IDLE, RD, WR, POLL, RESP.
- IDLE
  - cmd_ready=1.
  - On cmd_valid&cmd_ready, latch op, addr, data and mask; io_addr takes cmd_addr on the same edge.
  - Next state by op: WRITE→WR, READ/SET/CLR→RD, POLL→POLL, reserved→RESP.
- WR
  - io_we=1, io_wdata = write value. Next state is RESP.
  - Write value is cmd_data for WRITE, captured|data for SET, captured&~data for CLR.
  - rsp_data = write value, rsp_err=0.
- RD
  - io_we=0; io_rdata is captured at the edge ending the cycle.
  - READ→RESP with rsp_data = captured value.
  - SET/CLR→WR.
- POLL
  - One sample per cycle; the sample counter starts at 0.
  - Match when (io_rdata & mask) == (data & mask); then go to RESP with rsp_data=sample, rsp_err=0.
  - If the sample is not a match and it is sample number POLL_LIMIT, go to RESP with rsp_data=last sample, rsp_err=1.
  - Mask 0x00 always matches on the first sample.
- Reserved op: RESP with rsp_data=0x00, rsp_err=1. No bus cycle is issued (io_we stays 0).
- RESP
  - rsp_valid=1; rsp_data and rsp_err are held stable until rsp_valid&rsp_ready.
  - On that handshake, go to IDLE.
- io_we is high only in WR, so each SET, CLR or WRITE produces exactly one write pulse.
- io_addr and io_wdata keep their last value outside active states.

## Timing

- Reset
  - Synchronous: takes effect at the rising edge where reset=1.
  - Reset values: state IDLE, cmd_ready=1, rsp_valid=0, rsp_data=0x00, rsp_err=0, busy=0, io_addr=0x00, io_we=0, io_wdata=0x00, poll counter 0.
  - Reset during any state aborts the command: no response is produced and no further io_we pulse occurs after that edge.
- Command accepted at edge E. Earliest rsp_valid:
  - WRITE, READ: E+2.
  - SET, CLR: E+3.
  - POLL matching on sample k (1-based): E+1+k.
  - Reserved op: E+1.
- Write cycles: the io_we pulse is in cycle E+1 (WRITE) or E+2 (SET/CLR); the I/O register updates at the end of that cycle.
- Response consumption: rsp_valid&rsp_ready at edge R gives cmd_ready=1 in cycle R+1.
- No command overlap: at most one outstanding command.
- cmd_* inputs are ignored outside IDLE.
- Poll counter is 16 bits and never wraps; POLL_LIMIT caps it.

## Test plan

- WRITE 0x5A to 0x3c, then READ 0x3c.
  - Expect one io_we pulse with addr 0x3c, wdata 0x5A.
  - The READ returns rsp_data=0x5A, rsp_err=0; the WRITE response appears at E+2.
- Preload 0x81=0xF0. SET 0x0F, then CLR 0x30.
  - SET responds 0xFF and CLR responds 0xCF.
  - Exactly one io_we pulse per command; rsp_valid at E+3.
- POLL 0x01 with mask 0x80, data 0x80. A second stimulus writes 0x80 into the register during the 3rd sample.
  - Expect rsp_data=0x80, rsp_err=0 after 3 samples.
- POLL_LIMIT=4, register stays 0x00, poll for 0x01/0x01.
  - Expect exactly 4 POLL cycles, then rsp_err=1, rsp_data=0x00.
- Reserved op 6, plus response backpressure.
  - Op 6 returns rsp_err=1 with no io_we pulse.
  - Holding rsp_ready=0 for 5 cycles keeps rsp_valid, rsp_data and rsp_err constant and cmd_ready=0.
- Reset asserted for 1 cycle mid-POLL.
  - Next cycle: IDLE, rsp_valid=0, cmd_ready=1, io_we=0; no stale response.
  - A following READ works normally.
